// File: rtl/arb_rr21_pkg.sv
// Shared constants and the round-robin pick rule for the arb_rr21 feeder.
// A select value of 1 routes ln1 through the mux and 0 routes ln2.
package arb_rr21_pkg;

  localparam int   WIDTH_DEF = 8;
  localparam logic SEL_LN1   = 1'b1;
  localparam logic SEL_LN2   = 1'b0;

  // last=1 means ln1 was served most recently, so a tie goes to ln2.
  function automatic logic rr_pick(input logic v1, input logic v2, input logic last);
    logic sel;
    sel = ~last;
    if (v1 && !v2)      sel = SEL_LN1;
    else if (v2 && !v1) sel = SEL_LN2;
    return sel;
  endfunction

endpackage

// File: rtl/arb_rr21_mux21.sv
// 8-bit 2:1 data mux: A=1 selects ln1 and A=0 selects ln2.
module mux21
  import arb_rr21_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] ln1,
  input  logic [WIDTH-1:0] ln2,
  input  logic             A,
  output logic [WIDTH-1:0] Art
);

  assign Art = (A == SEL_LN1) ? ln1 : ln2;

endmodule

// File: rtl/arb_rr21.sv
// Round-robin 2:1 arbiter that feeds mux21 and registers its result into a
// one-entry valid/ready output stage. The block also keeps a wrapping count of accepted words per source.
module arb_rr21
  import arb_rr21_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ln1,
  input  logic             ln1_valid,
  output logic             ln1_ready,
  input  logic [WIDTH-1:0] ln2,
  input  logic             ln2_valid,
  output logic             ln2_ready,
  output logic             A,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic             last;
  logic             ld_en;
  logic             sel_valid;
  logic [WIDTH-1:0] art;

  // Stage 0: combinational arbitration and mux
  assign ld_en     = ~out_valid | out_ready;
  assign A         = rr_pick(ln1_valid, ln2_valid, last);
  assign ln1_ready = ld_en & A;
  assign ln2_ready = ld_en & ~A;
  assign sel_valid = A ? ln1_valid : ln2_valid;

  mux21 #(.WIDTH(WIDTH)) u_mux21 (
    .ln1 (ln1),
    .ln2 (ln2),
    .A   (A),
    .Art (art)
  );

  // Stage 1: output register, fairness state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      cnt1      <= '0;
      cnt2      <= '0;
    end else if (ld_en) begin
      if (sel_valid) begin
        out_data  <= art;
        out_valid <= 1'b1;
        last      <= A;
        if (A == SEL_LN1) cnt1 <= cnt1 + 1'b1;
        else              cnt2 <= cnt2 + 1'b1;
      end else begin
        // Nothing to reload: drain the held word and keep its data.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_rr21.sv
// Bench for arb_rr21. It runs directed vectors, hand-written corner sequences
// (async reset, counter wrap), and random traffic against a reference model.
module tb_arb_rr21;

  logic       clk;
  logic       rst_n;
  logic [7:0] ln1, ln2;
  logic       ln1_valid, ln2_valid;
  logic       ln1_ready, ln2_ready;
  logic       A;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cnt1, cnt2;

  int n_pass;
  int n_total;

  arb_rr21 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ln1       (ln1),
    .ln1_valid (ln1_valid),
    .ln1_ready (ln1_ready),
    .ln2       (ln2),
    .ln2_valid (ln2_valid),
    .ln2_ready (ln2_ready),
    .A         (A),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v1, v2;
    logic [7:0] d1, d2;
    logic       ordy;
    logic       ea, er1, er2;
    logic [7:0] eod;
    logic       eov;
    logic [7:0] ec1, ec2;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: the held output word, the counters, and which
  // source is owed the next tie.
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_c1, m_c2;
  logic       m_tie_ln1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drv(input logic v1, input logic v2, input logic [7:0] d1,
                     input logic [7:0] d2, input logic ordy);
    ln1_valid = v1; ln2_valid = v2; ln1 = d1; ln2 = d2; out_ready = ordy;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_c1 = 8'h00; m_c2 = 8'h00; m_tie_ln1 = 1'b1;
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  function automatic vec_t mk(input logic v1, input logic v2, input logic [7:0] d1,
                              input logic [7:0] d2, input logic ordy, input logic ea,
                              input logic er1, input logic er2, input logic [7:0] eod,
                              input logic eov, input logic [7:0] ec1, input logic [7:0] ec2);
    vec_t v;
    v.v1 = v1; v.v2 = v2; v.d1 = d1; v.d2 = d2; v.ordy = ordy;
    v.ea = ea; v.er1 = er1; v.er2 = er2; v.eod = eod; v.eov = eov; v.ec1 = ec1; v.ec2 = ec2;
    return v;
  endfunction

  // One random cycle: predict handshake from the rules, check, then advance.
  task automatic rand_cycle();
    logic v1, v2, ordy, ld, pick1, win;
    logic [7:0] d1, d2;
    v1 = ($urandom_range(0, 99) < 60);
    v2 = ($urandom_range(0, 99) < 60);
    ordy = ($urandom_range(0, 99) < 70);
    d1 = 8'($urandom); d2 = 8'($urandom);
    drv(v1, v2, d1, d2, ordy);
    ld = !m_valid || ordy;
    if (v1 != v2) pick1 = v1;
    else          pick1 = m_tie_ln1;
    #3;
    chk("rnd_A", A, pick1);
    chk("rnd_ln1_ready", ln1_ready, ld && pick1);
    chk("rnd_ln2_ready", ln2_ready, ld && !pick1);
    win = pick1 ? v1 : v2;
    if (ld) begin
      if (win) begin
        m_valid = 1'b1;
        m_data = pick1 ? d1 : d2;
        m_tie_ln1 = !pick1;
        if (pick1) m_c1 = m_c1 + 8'd1;
        else       m_c2 = m_c2 + 8'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("rnd_out_valid", out_valid, m_valid);
    chk("rnd_out_data", out_data, m_data);
    chk("rnd_cnt1", cnt1, m_c1);
    chk("rnd_cnt2", cnt2, m_c2);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    //          v1 v2 d1     d2     rdy  A  r1 r2 out    ov c1    c2
    tbl[0]  = mk(1, 1, 8'h11, 8'hC1, 1, 1, 1, 0, 8'h11, 1, 8'd1, 8'd0);
    tbl[1]  = mk(1, 1, 8'h22, 8'hC1, 1, 0, 0, 1, 8'hC1, 1, 8'd1, 8'd1);
    tbl[2]  = mk(1, 1, 8'h22, 8'hC2, 1, 1, 1, 0, 8'h22, 1, 8'd2, 8'd1);
    tbl[3]  = mk(1, 1, 8'h33, 8'hC2, 1, 0, 0, 1, 8'hC2, 1, 8'd2, 8'd2);
    tbl[4]  = mk(1, 0, 8'hA5, 8'h00, 1, 1, 1, 0, 8'hA5, 1, 8'd3, 8'd2);
    tbl[5]  = mk(1, 1, 8'h5A, 8'hC3, 0, 0, 0, 0, 8'hA5, 1, 8'd3, 8'd2);
    tbl[6]  = mk(1, 1, 8'h5A, 8'hC3, 0, 0, 0, 0, 8'hA5, 1, 8'd3, 8'd2);
    tbl[7]  = mk(1, 1, 8'h5A, 8'hC3, 0, 0, 0, 0, 8'hA5, 1, 8'd3, 8'd2);
    tbl[8]  = mk(1, 1, 8'h5A, 8'hC3, 1, 0, 0, 1, 8'hC3, 1, 8'd3, 8'd3);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'hC3, 0, 8'd3, 8'd3);
    tbl[10] = mk(0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 8'hC3, 0, 8'd3, 8'd3);
    tbl[11] = mk(0, 1, 8'h00, 8'h77, 0, 0, 0, 1, 8'h77, 1, 8'd3, 8'd4);
    tbl[12] = mk(1, 0, 8'h88, 8'h00, 0, 1, 0, 0, 8'h77, 1, 8'd3, 8'd4);

    do_reset();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_cnt1", cnt1, 8'h00);
    chk("reset_cnt2", cnt2, 8'h00);

    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].v1, tbl[i].v2, tbl[i].d1, tbl[i].d2, tbl[i].ordy);
      #3;
      chk($sformatf("vec%0d_A", i), A, tbl[i].ea);
      chk($sformatf("vec%0d_ln1_ready", i), ln1_ready, tbl[i].er1);
      chk($sformatf("vec%0d_ln2_ready", i), ln2_ready, tbl[i].er2);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].eod);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("vec%0d_cnt1", i), cnt1, tbl[i].ec1);
      chk($sformatf("vec%0d_cnt2", i), cnt2, tbl[i].ec2);
    end

    // Asynchronous reset in mid-stream, with a word held and stalled.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_data", out_data, 8'h00);
    chk("async_rst_cnt1", cnt1, 8'h00);
    chk("async_rst_cnt2", cnt2, 8'h00);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();

    // Counter wrap: two ln1 words, then 256 ln2 words at full throughput.
    drv(1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_pre_cnt1", cnt1, 8'd2);
    for (int k = 0; k < 256; k++) begin
      drv(1'b0, 1'b1, 8'h00, 8'(k), 1'b1);
      @(posedge clk); #1;
      if (k == 254) chk("wrap_cnt2_ff", cnt2, 8'hFF);
    end
    chk("wrap_cnt2_00", cnt2, 8'h00);
    chk("wrap_cnt1_hold", cnt1, 8'd2);
    chk("wrap_last_data", out_data, 8'hFF);

    // Random traffic checked against the model.
    do_reset();
    for (int n = 0; n < 400; n++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
